gpio_pad_ctrl: RTL and testbench

//  Core-side controller for a bank of bidirectional pull pads (PDU/PDD style).

---
 rtl/gpio_pad_pkg.sv | 24 ++
 rtl/gpio_pad_ctrl_if.sv | 29 ++
 rtl/gpio_pad_filter.sv | 58 +++++
 rtl/gpio_pad_ctrl.sv | 111 +++++++++++
 tb/tb_gpio_pad_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared types and constants for the GPIO pad controller.
//   FILT_W        width of the per-pad glitch-filter threshold
//   pad_cfg_t     per-pad configuration {oe, pu, out, filt}
//   cfg_state_e   configuration FSM states
//   PAD_CFG_RESET safe pad state: output off, pull on, threshold 0
package gpio_pad_pkg;

  localparam int unsigned FILT_W = 4;

  typedef struct packed {
    logic              oe;
    logic              pu;
    logic              out;
    logic [FILT_W-1:0] filt;
  } pad_cfg_t;

  typedef enum logic [0:0] {
    CFG_IDLE,
    CFG_APPLY
  } cfg_state_e;

  localparam pad_cfg_t PAD_CFG_RESET = '{oe: 1'b0, pu: 1'b1, out: 1'b0, filt: '0};

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if: valid/ready configuration port of the GPIO pad controller.
//   cfg_valid/cfg_ready  handshake
//   cfg_pad              target pad index (IDX_W bits)
//   cfg_oe/pu/out/filt   new configuration for that pad
// master = core/MMIO side, slave = controller.
interface gpio_pad_ctrl_if #(
  parameter int unsigned IDX_W = 2
) ();
  import gpio_pad_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_pad;
  logic              cfg_oe;
  logic              cfg_pu;
  logic              cfg_out;
  logic [FILT_W-1:0] cfg_filt;

  modport master (
    output cfg_valid, cfg_pad, cfg_oe, cfg_pu, cfg_out, cfg_filt,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pad, cfg_oe, cfg_pu, cfg_out, cfg_filt,
    output cfg_ready
  );

endinterface

// File: rtl/gpio_pad_filter.sv
// gpio_pad_filter: input path of one pad.
//   clock, reset     clock and synchronous active-high reset
//   pad_c            asynchronous pad read data
//   filt             stable-count threshold (rd_val follows after filt+1 differing cycles)
//   cfg_wr           configuration write to this pad; restarts the filter count
//   irq_clr          clears both edge flags
//   rd_val           filtered, synchronised pad value
//   rise_irq/fall_irq sticky edge flags on rd_val
module gpio_pad_filter
  import gpio_pad_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pad_c,
  input  logic [FILT_W-1:0] filt,
  input  logic              cfg_wr,
  input  logic              irq_clr,
  output logic              rd_val,
  output logic              rise_irq,
  output logic              fall_irq
);

  logic              sync1_q;
  logic              sync2_q;
  logic              prev_q;
  logic [FILT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      rd_val   <= 1'b0;
      rise_irq <= 1'b0;
      fall_irq <= 1'b0;
    end else begin
      // Undriven or unknown pads read as 0.
      sync1_q <= (pad_c === 1'b1);
      sync2_q <= sync1_q;
      prev_q  <= rd_val;

      if (cfg_wr || (sync2_q == rd_val)) begin
        cnt_q <= '0;
      end else if (cnt_q == filt) begin
        rd_val <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A new edge takes priority over a simultaneous clear.
      rise_irq <= (rd_val & ~prev_q) | (rise_irq & ~irq_clr);
      fall_irq <= (~rd_val & prev_q) | (fall_irq & ~irq_clr);
    end
  end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for a bank of bidirectional pull pads.
//   clock, reset   clock and synchronous active-high reset
//   cfg            configuration port (slave), one pad per transfer
//   pad_I          write data to pads
//   pad_OEN        active-low output enable to pads
//   pad_REN        active-low pull enable to pads
//   pad_C          asynchronous read data from pads
//   rd_val         filtered pad values
//   rise_irq/fall_irq sticky edge flags; irq_clr clears both flags of a pad
// A request is latched in CFG_IDLE and written to the pad registers at the end of
// CFG_APPLY, so at most one configuration is accepted every two cycles.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = 4,
  parameter int unsigned IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  gpio_pad_ctrl_if.slave      cfg,
  output logic [NUM_PADS-1:0] pad_I,
  output logic [NUM_PADS-1:0] pad_OEN,
  output logic [NUM_PADS-1:0] pad_REN,
  input  logic [NUM_PADS-1:0] pad_C,
  output logic [NUM_PADS-1:0] rd_val,
  output logic [NUM_PADS-1:0] rise_irq,
  output logic [NUM_PADS-1:0] fall_irq,
  input  logic [NUM_PADS-1:0] irq_clr
);

  cfg_state_e       state_q;
  logic             ready_q;
  pad_cfg_t         req_q;
  logic [IDX_W-1:0] req_pad_q;
  pad_cfg_t         pad_cfg_q [NUM_PADS];

  logic [NUM_PADS-1:0] pad_wr;

  // Out-of-range indices match no pad, so the handshake completes without effect.
  always_comb begin
    pad_wr = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_wr[i] = (state_q == CFG_APPLY) && (int'(req_pad_q) == i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CFG_IDLE;
      ready_q   <= 1'b1;
      req_q     <= PAD_CFG_RESET;
      req_pad_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        pad_cfg_q[i] <= PAD_CFG_RESET;
      end
    end else begin
      case (state_q)
        CFG_IDLE: begin
          if (cfg.cfg_valid) begin
            req_q     <= '{oe: cfg.cfg_oe, pu: cfg.cfg_pu, out: cfg.cfg_out,
                           filt: cfg.cfg_filt};
            req_pad_q <= cfg.cfg_pad;
            state_q   <= CFG_APPLY;
            ready_q   <= 1'b0;
          end
        end
        CFG_APPLY: begin
          for (int i = 0; i < NUM_PADS; i++) begin
            if (pad_wr[i]) begin
              pad_cfg_q[i] <= req_q;
            end
          end
          state_q <= CFG_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CFG_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;

  always_comb begin
    pad_I   = '0;
    pad_OEN = '1;
    pad_REN = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_I[i]   = pad_cfg_q[i].out;
      pad_OEN[i] = ~pad_cfg_q[i].oe;
      pad_REN[i] = ~pad_cfg_q[i].pu;
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    gpio_pad_filter u_filter (
      .clock    (clock),
      .reset    (reset),
      .pad_c    (pad_C[g]),
      .filt     (pad_cfg_q[g].filt),
      .cfg_wr   (pad_wr[g]),
      .irq_clr  (irq_clr[g]),
      .rd_val   (rd_val[g]),
      .rise_irq (rise_irq[g]),
      .fall_irq (fall_irq[g])
    );
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: self-checking bench for gpio_pad_ctrl (4 pads, 3-bit pad index so
// out-of-range indices can be driven). Expected pad outputs are queued when a config
// is accepted and compared by a monitor whenever cfg_ready returns high.
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned IW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] pad_I, pad_OEN, pad_REN, rd_val, rise_irq, fall_irq;
  logic [NP-1:0] pad_C   = '0;
  logic [NP-1:0] irq_clr = '0;

  gpio_pad_ctrl_if #(.IDX_W(IW)) cfg_bus ();

  gpio_pad_ctrl #(.NUM_PADS(NP), .IDX_W(IW)) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg      (cfg_bus),
    .pad_I    (pad_I),
    .pad_OEN  (pad_OEN),
    .pad_REN  (pad_REN),
    .pad_C    (pad_C),
    .rd_val   (rd_val),
    .rise_irq (rise_irq),
    .fall_irq (fall_irq),
    .irq_clr  (irq_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NP-1:0] i;
    logic [NP-1:0] oen;
    logic [NP-1:0] ren;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [NP-1:0] m_oe  = '0;
  logic [NP-1:0] m_pu  = '1;
  logic [NP-1:0] m_out = '0;
  logic          rdy_prev = 1'b1;
  int            tests_run = 0;
  int            tests_failed = 0;

  // Scoreboard monitor: pad outputs settle on the edge that returns cfg_ready high.
  always @(negedge clock) begin
    if (cfg_bus.cfg_ready === 1'b1 && rdy_prev !== 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_empty: cfg completed with no expected entry queued");
      end else begin
        mon_e = sb_q.pop_front();
        if ({pad_I, pad_OEN, pad_REN} !== {mon_e.i, mon_e.oen, mon_e.ren}) begin
          tests_failed++;
          $display("FAIL sb_pad_out: I/OEN/REN got %b/%b/%b want %b/%b/%b",
                   pad_I, pad_OEN, pad_REN, mon_e.i, mon_e.oen, mon_e.ren);
        end
      end
    end
    rdy_prev = cfg_bus.cfg_ready;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input int pad, input logic oe, input logic pu, input logic out);
    exp_t e;
    if (pad < NP) begin
      m_oe[pad]  = oe;
      m_pu[pad]  = pu;
      m_out[pad] = out;
    end
    e.i   = m_out;
    e.oen = ~m_oe;
    e.ren = ~m_pu;
    sb_q.push_back(e);
  endtask

  // Presents one request and returns in the APPLY cycle after acceptance.
  task automatic do_cfg(input int pad, input logic oe, input logic pu, input logic out,
                        input int filt);
    int waited = 0;
    cfg_bus.cfg_pad   = pad[IW-1:0];
    cfg_bus.cfg_oe    = oe;
    cfg_bus.cfg_pu    = pu;
    cfg_bus.cfg_out   = out;
    cfg_bus.cfg_filt  = filt[FILT_W-1:0];
    cfg_bus.cfg_valid = 1'b1;
    while (cfg_bus.cfg_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    if (cfg_bus.cfg_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cfg_timeout: cfg_ready got %b want 1 within 10 cycles",
               cfg_bus.cfg_ready);
      cfg_bus.cfg_valid = 1'b0;
      return;
    end
    push_exp(pad, oe, pu, out);
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (pad_OEN !== 4'b1111) begin
      tests_failed++; $display("FAIL reset_oen: got %b want 1111", pad_OEN);
    end
    tests_run++;
    if (pad_REN !== 4'b0000 || pad_I !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ren_i: got %b/%b want 0000/0000", pad_REN, pad_I);
    end
    tests_run++;
    if ({rd_val, rise_irq, fall_irq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_in: rd/rise/fall got %b/%b/%b want 0", rd_val, rise_irq, fall_irq);
    end
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", cfg_bus.cfg_ready);
    end
  endtask

  task automatic test_cfg_pad2();
    do_cfg(2, 1'b1, 1'b0, 1'b1, 0);
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_ready_low: got %b want 0", cfg_bus.cfg_ready);
    end
    tests_run++;
    if (pad_OEN !== 4'b1111) begin
      tests_failed++; $display("FAIL cfg_early: OEN got %b want 1111 during apply", pad_OEN);
    end
    tick();
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL cfg_ready_back: got %b want 1", cfg_bus.cfg_ready);
    end
    tests_run++;
    if ({pad_OEN, pad_I, pad_REN} !== {4'b1011, 4'b0100, 4'b0100}) begin
      tests_failed++;
      $display("FAIL cfg_pad2: OEN/I/REN got %b/%b/%b want 1011/0100/0100",
               pad_OEN, pad_I, pad_REN);
    end
  endtask

  task automatic test_filter_zero();
    pad_C[0] = 1'b1;
    tick(2);
    tests_run++;
    if (rd_val[0] !== 1'b0) begin
      tests_failed++; $display("FAIL f0_early: rd_val[0] got %b want 0", rd_val[0]);
    end
    tick();
    tests_run++;
    if (rd_val[0] !== 1'b1 || rise_irq[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL f0_rise: rd/rise got %b/%b want 1/0", rd_val[0], rise_irq[0]);
    end
    tick();
    tests_run++;
    if (rise_irq[0] !== 1'b1) begin
      tests_failed++; $display("FAIL f0_irq: rise_irq[0] got %b want 1", rise_irq[0]);
    end
    irq_clr[0] = 1'b1;
    tick();
    irq_clr[0] = 1'b0;
    tests_run++;
    if (rise_irq[0] !== 1'b0) begin
      tests_failed++; $display("FAIL f0_clr: rise_irq[0] got %b want 0", rise_irq[0]);
    end
    pad_C[0] = 1'b0;
    tick(3);
    tests_run++;
    if (rd_val[0] !== 1'b0) begin
      tests_failed++; $display("FAIL f0_fall_rd: rd_val[0] got %b want 0", rd_val[0]);
    end
    tick();
    tests_run++;
    if (fall_irq[0] !== 1'b1) begin
      tests_failed++; $display("FAIL f0_fall_irq: fall_irq[0] got %b want 1", fall_irq[0]);
    end
    pad_C[0] = 1'b1;
    tick(3);
    irq_clr[0] = 1'b1;
    tick();
    irq_clr[0] = 1'b0;
    tests_run++;
    if (rise_irq[0] !== 1'b1 || fall_irq[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL f0_set_wins: rise/fall got %b/%b want 1/0", rise_irq[0], fall_irq[0]);
    end
    tick();
    tests_run++;
    if (rise_irq[0] !== 1'b1) begin
      tests_failed++; $display("FAIL f0_hold: rise_irq[0] got %b want 1", rise_irq[0]);
    end
  endtask

  task automatic test_filter_thresh();
    int bad = 0;
    do_cfg(1, 1'b0, 1'b1, 1'b0, 3);
    tick();
    pad_C[1] = 1'b1;
    tick(3);
    pad_C[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (rd_val[1] !== 1'b0) begin
        tests_failed++;
        bad++;
        $display("FAIL f3_short: cycle %0d rd_val[1] got %b want 0", k, rd_val[1]);
      end
    end
    pad_C[1] = 1'b1;
    tick(4);
    pad_C[1] = 1'b0;
    tick();
    tests_run++;
    if (rd_val[1] !== 1'b0) begin
      tests_failed++; $display("FAIL f3_cycle5: rd_val[1] got %b want 0", rd_val[1]);
    end
    tick();
    tests_run++;
    if (rd_val[1] !== 1'b1) begin
      tests_failed++; $display("FAIL f3_cycle6: rd_val[1] got %b want 1", rd_val[1]);
    end
    tick();
    tests_run++;
    if (rise_irq[1] !== 1'b1 || fall_irq[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL f3_flags: rise/fall got %b/%b want 1/0", rise_irq[1], fall_irq[1]);
    end
  endtask

  task automatic test_xz_oob();
    pad_C[3] = 1'bz;
    tick(5);
    tests_run++;
    if (rd_val[3] !== 1'b0) begin
      tests_failed++; $display("FAIL xz_read: rd_val[3] got %b want 0", rd_val[3]);
    end
    pad_C[3] = 1'b1;
    tick(3);
    tests_run++;
    if (rd_val[3] !== 1'b1) begin
      tests_failed++; $display("FAIL pad3_live: rd_val[3] got %b want 1", rd_val[3]);
    end
    pad_C[3] = 1'b0;
    do_cfg(7, 1'b1, 1'b0, 1'b1, 5);
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL oob_ready: got %b want 0", cfg_bus.cfg_ready);
    end
    tick();
    tests_run++;
    if ({pad_OEN, pad_I, pad_REN} !== {~m_oe, m_out, ~m_pu}) begin
      tests_failed++;
      $display("FAIL oob_nochange: OEN/I/REN got %b/%b/%b want %b/%b/%b",
               pad_OEN, pad_I, pad_REN, ~m_oe, m_out, ~m_pu);
    end
  endtask

  task automatic test_back_to_back();
    cfg_bus.cfg_pad   = 3'd0;
    cfg_bus.cfg_oe    = 1'b1;
    cfg_bus.cfg_pu    = 1'b1;
    cfg_bus.cfg_out   = 1'b1;
    cfg_bus.cfg_filt  = '0;
    cfg_bus.cfg_valid = 1'b1;
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready0: got %b want 1", cfg_bus.cfg_ready);
    end
    push_exp(0, 1'b1, 1'b1, 1'b1);
    tick();
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_ready1: got %b want 0", cfg_bus.cfg_ready);
    end
    cfg_bus.cfg_pad = 3'd3;
    cfg_bus.cfg_oe  = 1'b1;
    cfg_bus.cfg_pu  = 1'b0;
    cfg_bus.cfg_out = 1'b0;
    tick();
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b1 || pad_OEN[0] !== 1'b0 || pad_I[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: ready/OEN0/I0 got %b/%b/%b want 1/0/1",
               cfg_bus.cfg_ready, pad_OEN[0], pad_I[0]);
    end
    push_exp(3, 1'b1, 1'b0, 1'b0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    tests_run++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_ready2: got %b want 0", cfg_bus.cfg_ready);
    end
    tick();
    tests_run++;
    if (pad_OEN[3] !== 1'b0 || pad_REN[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: OEN3/REN3 got %b/%b want 0/1", pad_OEN[3], pad_REN[3]);
    end
  endtask

  task automatic test_reset_mid();
    pad_C[1] = 1'b1;
    tick(4);
    do_cfg(0, 1'b0, 1'b0, 1'b0, 2);
    // The pending apply is aborted; the next ready edge must show reset outputs.
    sb_q.delete();
    m_oe  = '0;
    m_pu  = '1;
    m_out = '0;
    push_exp(NP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tests_run++;
    if ({pad_OEN, pad_REN, pad_I} !== {4'b1111, 4'b0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL rst_mid_pads: OEN/REN/I got %b/%b/%b want 1111/0000/0000",
               pad_OEN, pad_REN, pad_I);
    end
    tests_run++;
    if ({rd_val, rise_irq, fall_irq} !== '0 || cfg_bus.cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_in: rd/rise/fall/ready got %b/%b/%b/%b want 0/0/0/1",
               rd_val, rise_irq, fall_irq, cfg_bus.cfg_ready);
    end
    reset    = 1'b0;
    pad_C[1] = 1'b0;
    tick(2);
  endtask

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_pad   = '0;
    cfg_bus.cfg_oe    = 1'b0;
    cfg_bus.cfg_pu    = 1'b0;
    cfg_bus.cfg_out   = 1'b0;
    cfg_bus.cfg_filt  = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    test_reset();
    test_cfg_pad2();
    test_filter_zero();
    test_filter_thresh();
    test_xz_oob();
    test_back_to_back();
    test_reset_mid();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d expected entries never matched, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
